// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the L1-to-DRAM FIFO arbiter and its wrappers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ISSUE    = 2'd1,
        WAIT_RSP = 2'd2,
        DONE     = 2'd3
    } arb_state_t;

    localparam logic CMD_WRITE = 1'b0;
    localparam logic CMD_READ  = 1'b1;

    localparam int L2_ADDR_W = 27;
    localparam int L2_DATA_W = 128;

    // Request/response bundles used by the L1 cache wrappers.
    typedef struct packed {
        logic [L2_ADDR_W-1:0] addr;
        logic [L2_DATA_W-1:0] data;
        logic                 rw;
        logic                 valid;
    } L2_req_type;

    typedef struct packed {
        logic [L2_DATA_W-1:0] data;
        logic                 ready;
    } mem_data_type;

endpackage

// File: rtl/rr_grant2.sv
// Two-way grant between ic and dc: round-robin with a prio flop, or fixed dc-first.
module rr_grant2 #(
    parameter int FIXED_PRIO = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic req_ic,
    input  logic req_dc,
    input  logic en,
    output logic gnt_dc
);

    logic prio;

    always_comb begin
        gnt_dc = 1'b0;
        if (FIXED_PRIO != 0) begin
            gnt_dc = req_dc;
        end else begin
            gnt_dc = req_dc & (~req_ic | prio);
        end
    end

    // prio only moves on a contested grant, and then points at the loser.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (en && req_ic && req_dc && (FIXED_PRIO == 0)) begin
            prio <= ~gnt_dc;
        end
    end

endmodule

// File: rtl/dram_arbiter.sv
// Shares one DRAM FIFO port between the ic and dc L1 caches, one transaction at a time,
// routing each response to the issuing side and flagging timeouts and stray responses.
module dram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 27,
    parameter int DATA_W      = 128,
    parameter int TIMEOUT_CYC = 4096,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] ic_req_addr,
    input  logic [DATA_W-1:0] ic_req_data,
    input  logic              ic_req_rw,
    input  logic              ic_req_valid,
    output logic [DATA_W-1:0] ic_rsp_data,
    output logic              ic_rsp_ready,
    input  logic [ADDR_W-1:0] dc_req_addr,
    input  logic [DATA_W-1:0] dc_req_data,
    input  logic              dc_req_rw,
    input  logic              dc_req_valid,
    output logic [DATA_W-1:0] dc_rsp_data,
    output logic              dc_rsp_ready,
    output logic              mem_req_cmd,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_req_data,
    output logic              mem_req_en,
    input  logic              mem_req_rdy,
    input  logic [DATA_W-1:0] mem_rsp_data,
    input  logic              mem_rsp_en,
    output logic              mem_rsp_rdy,
    output logic              busy,
    output logic              owner,
    output logic              timeout_err,
    output logic              stray_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

    arb_state_t       state;
    logic [CNT_W-1:0] cnt;
    logic             gnt_dc;
    logic             any_req;
    logic             timeout_hit;

    rr_grant2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_grant (
        .clk    (CLK),
        .rst    (RST),
        .req_ic (ic_req_valid),
        .req_dc (dc_req_valid),
        .en     (state == IDLE),
        .gnt_dc (gnt_dc)
    );

    assign any_req      = ic_req_valid | dc_req_valid;
    assign timeout_hit  = (cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign mem_rsp_rdy  = 1'b1;
    assign busy         = (state != IDLE);
    assign ic_rsp_ready = (state == DONE) && !owner;
    assign dc_rsp_ready = (state == DONE) && owner;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state        <= IDLE;
            owner        <= 1'b0;
            cnt          <= '0;
            mem_req_en   <= 1'b0;
            mem_req_cmd  <= 1'b0;
            mem_req_addr <= '0;
            mem_req_data <= '0;
            ic_rsp_data  <= '0;
            dc_rsp_data  <= '0;
            timeout_err  <= 1'b0;
            stray_err    <= 1'b0;
        end else begin
            // Responses outside WAIT_RSP are dropped; only the flag records them.
            if (mem_rsp_en && (state != WAIT_RSP)) begin
                stray_err <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (any_req) begin
                        owner        <= gnt_dc;
                        mem_req_addr <= gnt_dc ? dc_req_addr : ic_req_addr;
                        mem_req_data <= gnt_dc ? dc_req_data : ic_req_data;
                        mem_req_cmd  <= gnt_dc ? ~dc_req_rw : ~ic_req_rw;
                        mem_req_en   <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (mem_req_rdy) begin
                        mem_req_en <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    cnt <= cnt + CNT_W'(1);
                    // A response on the timeout cycle still wins.
                    if (mem_rsp_en) begin
                        if (owner) begin
                            dc_rsp_data <= mem_rsp_data;
                        end else begin
                            ic_rsp_data <= mem_rsp_data;
                        end
                        state <= DONE;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        if (owner) begin
                            dc_rsp_data <= '0;
                        end else begin
                            ic_rsp_data <= '0;
                        end
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
